// File: rtl/design_assertions_fairness_monitor_if.sv
// Observed request/grant/error channels plus the external interrupt line.
// The environment drives every signal; the monitor only samples and never back-pressures.
interface design_assertions_fairness_monitor_if #(
  parameter int NCH = 2
) ();
  logic [NCH-1:0] ch_req;
  logic [NCH-1:0] ch_gnt;
  logic [NCH-1:0] ch_err;
  logic           int_ext;

  modport master (output ch_req, output ch_gnt, output ch_err, output int_ext);
  modport slave  (input  ch_req, input  ch_gnt, input  ch_err, input  int_ext);
endinterface

// File: rtl/design_assertions_fairness_monitor.sv
// Environment fairness monitor: grant latency, error legality and interrupt spacing,
// with sticky violation flags and a record of the first offending term.
module design_assertions_fairness_monitor #(
  parameter int NCH       = 2,
  parameter int MAX_STALL = 8,
  parameter int INT_GAP   = 16,
  parameter int CW        = $clog2(MAX_STALL + 1)
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  design_assertions_fairness_monitor_if.slave bus,
  output logic [NCH*CW-1:0]          stall_cnt,
  output logic [NCH-1:0]             gnt_fair,
  output logic [NCH-1:0]             err_fair,
  output logic                       int_fair,
  output logic                       fair_ok,
  output logic [NCH:0]               viol,
  output logic                       first_viol_vld,
  output logic [$clog2(NCH+1)-1:0]   first_viol_idx
);
  localparam int IW = $clog2(NCH + 1);
  localparam int GW = (INT_GAP > 1) ? $clog2(INT_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD  = GW'(INT_GAP - 1);
  localparam logic [CW-1:0] STALL_MAX = CW'(MAX_STALL);

  logic [NCH-1:0] w_gnt_bad;
  logic [NCH-1:0] w_err_bad;
  logic           w_rise;
  logic           w_int_bad;
  logic [NCH:0]   w_bad;
  logic [IW-1:0]  w_first_idx;

  logic           r_int_q;
  logic [GW-1:0]  r_gap;
  logic [NCH:0]   r_viol;
  logic           r_first_vld;
  logic [IW-1:0]  r_first_idx;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic          w_stalling;
    logic [CW-1:0] r_cnt;

    assign w_stalling    = bus.ch_req[gi] & ~bus.ch_gnt[gi];
    // A grant arriving while the count sits at the limit is still on time.
    assign w_gnt_bad[gi] = w_stalling & (r_cnt == STALL_MAX);
    assign w_err_bad[gi] = bus.ch_err[gi] & ~(bus.ch_req[gi] & bus.ch_gnt[gi]);
    assign stall_cnt[gi*CW +: CW] = r_cnt;

    always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
        r_cnt <= '0;
      end else if (w_stalling) begin
        if (r_cnt != STALL_MAX) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign w_rise    = bus.int_ext & ~r_int_q;
  assign w_int_bad = w_rise & (r_gap != '0);

  // Fairness terms read 1 throughout reset so the harness assumption is vacuous there.
  assign gnt_fair = ~w_gnt_bad | {NCH{~g_resetn}};
  assign err_fair = ~w_err_bad | {NCH{~g_resetn}};
  assign int_fair = ~w_int_bad | ~g_resetn;
  assign fair_ok  = (&gnt_fair) & (&err_fair) & int_fair;

  assign w_bad = {~int_fair, ~gnt_fair | ~err_fair};

  always_comb begin
    w_first_idx = '0;
    for (int i = NCH; i >= 0; i--) begin
      if (w_bad[i]) w_first_idx = IW'(i);
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_int_q     <= 1'b0;
      r_gap       <= '0;
      r_viol      <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
    end else begin
      r_int_q <= bus.int_ext;
      if (w_rise)              r_gap <= GAP_LOAD;
      else if (r_gap != '0)    r_gap <= r_gap - 1'b1;
      r_viol <= r_viol | w_bad;
      if (!r_first_vld && (|w_bad)) begin
        r_first_vld <= 1'b1;
        r_first_idx <= w_first_idx;
      end
    end
  end

  assign viol           = r_viol;
  assign first_viol_vld = r_first_vld;
  assign first_viol_idx = r_first_idx;
endmodule

// File: tb/tb_design_assertions_fairness_monitor.sv
// Directed bench for the fairness monitor: each stimulus cycle queues its hand-derived
// expected outputs, and an independent monitor pops and compares mid low-phase.
module tb_design_assertions_fairness_monitor;
  localparam int NCH = 2;
  localparam int CW  = 4;
  localparam int IW  = 2;

  typedef struct packed {
    logic [NCH*CW-1:0] stall;
    logic [NCH-1:0]    gf;
    logic [NCH-1:0]    ef;
    logic              intf;
    logic              ok;
    logic [NCH:0]      viol;
    logic              fv;
    logic [IW-1:0]     fi;
  } exp_t;

  logic              g_clk;
  logic              g_resetn;
  logic [NCH*CW-1:0] stall_cnt;
  logic [NCH-1:0]    gnt_fair;
  logic [NCH-1:0]    err_fair;
  logic              int_fair;
  logic              fair_ok;
  logic [NCH:0]      viol;
  logic              first_viol_vld;
  logic [IW-1:0]     first_viol_idx;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  design_assertions_fairness_monitor_if #(.NCH(NCH)) bus ();

  design_assertions_fairness_monitor #(.NCH(NCH), .MAX_STALL(8), .INT_GAP(16)) dut (
    .g_clk          (g_clk),
    .g_resetn       (g_resetn),
    .bus            (bus),
    .stall_cnt      (stall_cnt),
    .gnt_fair       (gnt_fair),
    .err_fair       (err_fair),
    .int_fair       (int_fair),
    .fair_ok        (fair_ok),
    .viol           (viol),
    .first_viol_vld (first_viol_vld),
    .first_viol_idx (first_viol_idx)
  );

  // Clock / reset
  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  initial begin
    g_resetn    = 1'b0;
    bus.ch_req  = '0;
    bus.ch_gnt  = '0;
    bus.ch_err  = '0;
    bus.int_ext = 1'b0;
  end

  // Driver: apply one cycle of inputs at the falling edge and queue what must be seen.
  task automatic step(input logic rstn, input logic [1:0] req, input logic [1:0] gnt,
                      input logic [1:0] err, input logic intx,
                      input logic [3:0] s0, input logic [3:0] s1,
                      input logic [1:0] gf, input logic [1:0] ef, input logic intf,
                      input logic [2:0] v, input logic fv, input logic [1:0] fi);
    exp_t e;
    @(negedge g_clk);
    g_resetn    = rstn;
    bus.ch_req  = req;
    bus.ch_gnt  = gnt;
    bus.ch_err  = err;
    bus.int_ext = intx;
    e.stall = {s1, s0};
    e.gf    = gf;
    e.ef    = ef;
    e.intf  = intf;
    e.ok    = (&gf) & (&ef) & intf;
    e.viol  = v;
    e.fv    = fv;
    e.fi    = fi;
    exp_q.push_back(e);
  endtask

  task automatic reset_step();
    step(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         4'd0, 4'd0, 2'b11, 2'b11, 1'b1, 3'b000, 1'b0, 2'd0);
  endtask

  // Scoreboard
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge g_clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("stall_cnt",      32'(stall_cnt),      32'(e.stall));
        cmp("gnt_fair",       32'(gnt_fair),       32'(e.gf));
        cmp("err_fair",       32'(err_fair),       32'(e.ef));
        cmp("int_fair",       32'(int_fair),       32'(e.intf));
        cmp("fair_ok",        32'(fair_ok),        32'(e.ok));
        cmp("viol",           32'(viol),           32'(e.viol));
        cmp("first_viol_vld", 32'(first_viol_vld), 32'(e.fv));
        cmp("first_viol_idx", 32'(first_viol_idx), 32'(e.fi));
      end
    end
  end

  // Directed stimulus
  initial begin
    reset_step();
    reset_step();

    // Aborted stall, then an exact-limit stall answered in time
    step(1, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);
    for (int k = 0; k < 3; k++)
      step(1, 2'b01, 2'b00, 2'b00, 0, 4'(k), 4'd0, 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 4'd3, 4'd0, 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);
    for (int k = 0; k < 8; k++)
      step(1, 2'b01, 2'b00, 2'b00, 0, 4'(k), 4'd0, 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);
    step(1, 2'b01, 2'b01, 2'b00, 0, 4'd8, 4'd0, 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);

    // Over-long stall on channel 0
    for (int k = 0; k < 8; k++)
      step(1, 2'b01, 2'b00, 2'b00, 0, 4'(k), 4'd0, 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);
    step(1, 2'b01, 2'b00, 2'b00, 0, 4'd8, 4'd0, 2'b10, 2'b11, 1, 3'b000, 0, 2'd0);
    step(1, 2'b01, 2'b01, 2'b00, 0, 4'd8, 4'd0, 2'b11, 2'b11, 1, 3'b001, 1, 2'd0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b001, 1, 2'd0);

    // Errors on channel 1: legal with grant, illegal without
    step(1, 2'b10, 2'b10, 2'b10, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b001, 1, 2'd0);
    step(1, 2'b00, 2'b00, 2'b10, 0, 4'd0, 4'd0, 2'b11, 2'b01, 1, 3'b001, 1, 2'd0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b011, 1, 2'd0);

    // Interrupt rises 16 apart (fair), then 15 apart (unfair)
    step(1, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b011, 1, 2'd0);
    for (int k = 1; k < 16; k++)
      step(1, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b011, 1, 2'd0);
    step(1, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b011, 1, 2'd0);
    for (int k = 17; k < 31; k++)
      step(1, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b011, 1, 2'd0);
    step(1, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd0, 2'b11, 2'b11, 0, 3'b011, 1, 2'd0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b111, 1, 2'd0);

    // Asynchronous reset in the middle of a 5-deep stall with flags set
    for (int k = 0; k < 5; k++)
      step(1, 2'b01, 2'b00, 2'b00, 0, 4'(k), 4'd0, 2'b11, 2'b11, 1, 3'b111, 1, 2'd0);
    step(0, 2'b01, 2'b00, 2'b00, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);
    reset_step();

    // Channel 1 over-stall coincides with an early interrupt rise: lowest index wins
    step(1, 2'b10, 2'b00, 2'b00, 1, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);
    for (int k = 1; k < 8; k++)
      step(1, 2'b10, 2'b00, 2'b00, 0, 4'd0, 4'(k), 2'b11, 2'b11, 1, 3'b000, 0, 2'd0);
    step(1, 2'b10, 2'b00, 2'b00, 1, 4'd0, 4'd8, 2'b01, 2'b11, 0, 3'b000, 0, 2'd0);
    step(1, 2'b10, 2'b10, 2'b00, 1, 4'd0, 4'd8, 2'b11, 2'b11, 1, 3'b110, 1, 2'd1);
    step(1, 2'b00, 2'b00, 2'b01, 1, 4'd0, 4'd0, 2'b11, 2'b10, 1, 3'b110, 1, 2'd1);
    step(1, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0, 2'b11, 2'b11, 1, 3'b111, 1, 2'd1);

    // Final report
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge g_clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/design_assertions_fairness_monitor.md
# design_assertions_fairness_monitor

Parametrised, synthesisable fairness monitor for the formal and designer-assertions environment of the core. It observes N request/grant memory channels and the external interrupt line. Each cycle it reports whether the environment is "playing fair": bounded grant latency, errors only with grants, and a minimum spacing between interrupts. The harness places `assume(fair_ok)` on its outputs. Sticky violation flags and the first offending channel are kept for debug and cover points.

## Interface
Parameters
- `NCH`, 2, number of req/gnt channels (imem, dmem, …); ≥1
- `MAX_STALL`, 8, max consecutive cycles a request may wait without grant; ≥1
- `INT_GAP`, 16, min cycles between `int_ext` rising edges; ≥1 (1 = unconstrained)
- `CW`, `$clog2(MAX_STALL+1)`, stall counter width (derived; do not override)

Ports
- `g_clk` in 1 global clock
- `g_resetn` in 1 global reset, asynchronous, active-low
- `ch_req` in NCH per-channel request
- `ch_gnt` in NCH per-channel grant / response valid
- `ch_err` in NCH per-channel response error
- `int_ext` in 1 hardware interrupt
- `stall_cnt` out NCH*CW current consecutive-stall count per channel; channel i at `[i*CW +: CW]`
- `gnt_fair` out NCH channel i meets grant-latency bound this cycle
- `err_fair` out NCH channel i error is legal this cycle
- `int_fair` out 1 interrupt spacing is legal this cycle
- `fair_ok` out 1 AND of all fairness terms
- `viol` out NCH+1 sticky violation flags; bit i is channel i, bit NCH is interrupt
- `first_viol_vld` out 1 at least one violation has been recorded
- `first_viol_idx` out `$clog2(NCH+1)` index of the first violation (viol bit number)

## Operation
- Stall counter, per channel i:
  - `req & !gnt`: count increments, saturating at MAX_STALL.
  - Otherwise: count resets to 0.
- `gnt_fair[i] = !(req & !gnt & stall_cnt == MAX_STALL)`. The most a request may wait is MAX_STALL stall cycles. The grant must arrive by stall cycle MAX_STALL+1.
- `err_fair[i] = !(err & !(req & gnt))`.
- Interrupt spacing:
  - `int_q` registers `int_ext`. A rise is `int_ext & !int_q`.
  - On any rise, fair or not, the gap counter loads INT_GAP-1. Otherwise it decrements while nonzero.
  - `int_fair = !(rise & gap != 0)`.
- `fair_ok` = AND of all `gnt_fair`, all `err_fair`, and `int_fair`.
- While `g_resetn` is low, `gnt_fair`, `err_fair`, `int_fair` and `fair_ok` are forced to 1 combinationally. Inputs are unconstrained in reset.
- Sticky flags:
  - `viol[i]` sets on the clock edge after a cycle with `!gnt_fair[i] | !err_fair[i]`.
  - `viol[NCH]` sets after a cycle with `!int_fair`.
  - Flags clear only on reset.
- First violation:
  - `first_viol_idx` is captured on the edge where `first_viol_vld` goes 0→1.
  - If several bits fail in the same cycle, the lowest index wins.
  - Later violations do not change the index.

## Timing
- Reset values:
  - `stall_cnt` = 0, gap counter = 0, `int_q` = 0.
  - `viol` = 0, `first_viol_vld` = 0, `first_viol_idx` = 0.
  - `fair_ok` and the other fairness outputs read 1.
- Reset is asynchronous: assertion mid-stall clears counters and flags immediately. The first cycle after deassertion starts from a count of 0.
- The fairness outputs are combinational from current inputs plus registered state, so they are valid in the same cycle. Zero latency to `fair_ok`.
- Sticky flags and `first_viol_*` lag by one cycle.
- `req` falling without a grant clears the count. A new request restarts from 0.
- A grant in the same cycle as `stall_cnt == MAX_STALL` is fair.
- A rise exactly INT_GAP cycles after the previous rise is fair. INT_GAP-1 cycles after is unfair.
- Holding `int_ext` high produces no further rises and is always fair.

## Test plan
- Channel 0 stall, MAX_STALL=8: `req=1`, `gnt=0` for 8 cycles, then `gnt=1` → `stall_cnt` reaches 8, `gnt_fair`/`fair_ok` stay 1, count returns to 0, `viol=0`.
- Over-long stall: `req=1`, `gnt=0` for 9 cycles → `gnt_fair[0]=0` and `fair_ok=0` in cycle 9. Next cycle `viol[0]=1`, `first_viol_vld=1`, `first_viol_idx=0`. The flag stays set after `gnt`.
- Error checks:
  - `err=1` with `req=1`, `gnt=1` on channel 1 → `err_fair` stays 1.
  - `err=1` with `gnt=0` → `err_fair[1]=0`, then `viol[1]=1`.
- Interrupt spacing, INT_GAP=16: rises at cycles 0 and 16 → both fair. Rise at 0 then 15 → `int_fair=0` at cycle 15 and `viol[NCH]=1`.
- Simultaneous violations: channel 1 over-stall and an early interrupt rise in the same cycle → `first_viol_idx=1`, and both bits of `viol` set. A later channel 0 violation leaves the index at 1.
- Reset mid-operation: assert `g_resetn=0` asynchronously with `stall_cnt=5` and `viol≠0` → all counters and flags read 0 and `fair_ok=1` before the next clock edge. After release, a 9-cycle stall is needed again to flag.
